// File: rtl/uart_instruction_loader.sv
// uart_instruction_loader: 8N1 UART receiver that packs four bytes into a 32-bit word and presents it to the Controller for HOLD_CYCLES clocks.
module uart_instruction_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HOLD_CYCLES  = 4,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        ctrl_idle,
    output logic [31:0] instruction,
    output logic        pending,
    output logic        frame_error,
    output logic        overrun,
    output logic        timeout
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL      = CW'(CLKS_PER_BIT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_s1_q, rx_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   word_q, word_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   buf_q, buf_d, instr_q, instr_d;
    logic          pend_q, pend_d, act_q, act_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          fe_q, fe_d, ov_q, ov_d, tp_q, tp_d;
    logic          accept, ferr, done, start;
    logic [31:0]   full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        accept  = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == HALF) begin
                    state_d = rx_s2_q ? IDLE : DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == FULL) begin
                    state_d = IDLE;
                    accept  = rx_s2_q;
                    ferr    = !rx_s2_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bytes arrive strictly in index order, so a shift register places each one correctly.
    assign full = {word_q, shift_q};
    assign done = accept && (idx_q == 2'd3);

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        to_d   = to_q;
        tp_d   = 1'b0;
        if (accept) begin
            idx_d  = idx_q + 2'd1;
            word_d = {word_q[15:0], shift_q};
            to_d   = '0;
        end else if (ferr) begin
            idx_d  = '0;
            word_d = '0;
            to_d   = '0;
        end else if (idx_q == 2'd0) begin
            to_d = '0;
        end else if (state_q == IDLE) begin
            if (to_q == TO_LAST) begin
                idx_d  = '0;
                word_d = '0;
                to_d   = '0;
                tp_d   = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    assign start = pend_q && ctrl_idle && !act_q;

    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        hold_d  = hold_q;
        ov_d    = 1'b0;
        fe_d    = ferr;
        if (start) begin
            pend_d  = 1'b0;
            act_d   = 1'b1;
            instr_d = buf_q;
            hold_d  = HOLD_LAST;
        end else if (act_q) begin
            if (hold_q == '0) begin
                act_d   = 1'b0;
                instr_d = '0;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
        if (done && full != 32'd0) begin
            if (pend_q || act_q) begin
                ov_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                buf_d  = full;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            to_q    <= '0;
            buf_q   <= '0;
            instr_q <= '0;
            pend_q  <= 1'b0;
            act_q   <= 1'b0;
            hold_q  <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            tp_q    <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            to_q    <= to_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            hold_q  <= hold_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            tp_q    <= tp_d;
        end
    end

    assign instruction = instr_q;
    assign pending     = pend_q;
    assign frame_error = fe_q;
    assign overrun     = ov_q;
    assign timeout     = tp_q;
endmodule

// File: tb/tb_uart_instruction_loader.sv
// tb_uart_instruction_loader: directed UART stimulus with a queue-based scoreboard checking emitted instruction words.
module tb_uart_instruction_loader;
    localparam int CPB  = 4;
    localparam int HOLD = 4;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        ctrl_idle = 1'b1;
    logic [31:0] instruction;
    logic        pending, frame_error, overrun, timeout;

    uart_instruction_loader #(
        .CLKS_PER_BIT(CPB),
        .HOLD_CYCLES(HOLD),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .ctrl_idle(ctrl_idle),
        .instruction(instruction),
        .pending(pending),
        .frame_error(frame_error),
        .overrun(overrun),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          run = 0;
    int          n_emit = 0;
    int          t_emit = 0;
    int          t_start = 0;
    int          fe_n = 0;
    int          ov_n = 0;
    int          to_n = 0;
    logic [31:0] cur = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard at each emission start and checks word, stability and hold length.
    always @(negedge clk) begin
        fe_n += int'(frame_error);
        ov_n += int'(overrun);
        to_n += int'(timeout);
        if (rst) begin
            run = 0;
        end else if (instruction != 32'd0) begin
            if (run == 0) begin
                n_emit++;
                t_emit = cyc;
                cur = instruction;
                check("pending_clear", 32'(pending), 32'd0);
                if (exp_q.size() == 0) check("unexpected_word", instruction, 32'd0);
                else check("word", instruction, exp_q.pop_front());
            end else begin
                check("word_stable", instruction, cur);
            end
            run++;
        end else if (run != 0) begin
            check("hold_len", run, HOLD);
            run = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic push);
        if (push) exp_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*(3-i) +: 8], 1'b1);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic wait_emit(input int target);
        int k = 0;
        while (n_emit < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("emit_wait", n_emit, target);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_instruction", instruction, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_pulses", {29'd0, frame_error, overrun, timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_word(32'h04010000, 1'b1);
        wait_emit(1);
        check("latency", t_emit - t_start, 42);
        repeat (10) @(negedge clk);
        check("no_errors", fe_n + ov_n + to_n, 0);

        ctrl_idle = 1'b0;
        send_word(32'hDEADBEEF, 1'b1);
        repeat (50) @(negedge clk);
        #1;
        check("held_pending", 32'(pending), 32'd1);
        check("held_idle_bus", instruction, 32'd0);
        ctrl_idle = 1'b1;
        @(negedge clk);
        #1;
        check("release_word", instruction, 32'hDEADBEEF);
        wait_emit(2);
        repeat (10) @(negedge clk);

        ctrl_idle = 1'b0;
        send_word(32'h11223344, 1'b1);
        send_word(32'h55667788, 1'b0);
        repeat (5) @(negedge clk);
        check("overrun_count", ov_n, 1);
        check("overrun_pending", 32'(pending), 32'd1);
        ctrl_idle = 1'b1;
        wait_emit(3);
        repeat (20) @(negedge clk);
        check("single_emit", n_emit, 3);

        send_byte(8'hAA, 1'b1);
        repeat (250) @(negedge clk);
        check("timeout_count", to_n, 1);
        send_word(32'h01020304, 1'b1);
        wait_emit(4);
        repeat (10) @(negedge clk);

        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_error_count", fe_n, 1);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_word(32'hCAFEF00D, 1'b1);
        wait_emit(5);
        repeat (10) @(negedge clk);
        check("frame_error_once", fe_n, 1);

        ctrl_idle = 1'b0;
        send_word(32'h12345678, 1'b0);
        check("pre_rst_pending", 32'(pending), 32'd1);
        send_byte(8'h0A, 1'b1);
        repeat (3) @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_rx_instruction", instruction, 32'd0);
        check("rst_rx_pending", 32'(pending), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ctrl_idle = 1'b1;
        repeat (30) @(negedge clk);
        check("buffer_cleared", n_emit, 5);

        send_word(32'h0A0B0C0D, 1'b1);
        wait_emit(6);
        #1;
        rst = 1'b1;
        #1;
        check("rst_emit_instruction", instruction, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_word(32'h0A0B0C0D, 1'b1);
        wait_emit(7);
        repeat (20) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        check("final_overrun", ov_n, 1);
        check("final_timeout", to_n, 1);
        check("final_frame_error", fe_n, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
